// File: rtl/bus_arb4.sv
// Round-robin arbiter for the shared four-source datapath bus.
// Grants one requester at a time, registers its word onto OUT and forces rotation after MAX_HOLD beats.
module bus_arb4 #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [3:0]        REQ,
  input  logic [3:0]        LAST,
  input  logic [DATA_W-1:0] X0,
  input  logic [DATA_W-1:0] X1,
  input  logic [DATA_W-1:0] X2,
  input  logic [DATA_W-1:0] X3,
  output logic [3:0]        GNT,
  output logic [1:0]        SEL,
  output logic [DATA_W-1:0] OUT,
  output logic              VALID,
  output logic              HOLD_EXP
);

  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         gnt_d;
  logic [1:0]         sel_d;
  logic [DATA_W-1:0]  out_d;
  logic               valid_d;
  logic               hold_d;
  logic               rearb;
  logic [3:0]         elig;
  logic [1:0]         base;
  logic [3:0]         owner_oh;
  logic [2:0]         pick;
  logic [DATA_W-1:0]  xsel;

  // First set bit scanning base+1, base+2, base+3, base; returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] b);
    logic [2:0] r;
    logic [1:0] j;
    r = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      j = b + 2'(k);
      if (req[j]) r = {1'b1, j};
    end
    return r;
  endfunction

  always_comb begin
    case (SEL)
      2'd0:    xsel = X0;
      2'd1:    xsel = X1;
      2'd2:    xsel = X2;
      default: xsel = X3;
    endcase
  end

  assign owner_oh = 4'b0001 << SEL;

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = GNT;
    sel_d   = SEL;
    out_d   = OUT;
    valid_d = 1'b0;
    hold_d  = 1'b0;
    rearb   = 1'b0;
    elig    = REQ;
    base    = ptr_q;
    pick    = 3'b000;

    case (state_q)
      IDLE: begin
        rearb = |REQ;
      end
      OWN: begin
        base = SEL;
        // The releasing owner only competes when nobody else is asking.
        if (|(REQ & ~owner_oh)) elig = REQ & ~owner_oh;
        if (!REQ[SEL]) begin
          rearb = 1'b1;
        end else begin
          out_d   = xsel;
          valid_d = 1'b1;
          if (cnt_q == CNT_W'(MAX_HOLD)) begin
            hold_d = 1'b1;
            rearb  = 1'b1;
          end else if (LAST[SEL]) begin
            rearb = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rearb) begin
      pick = rr_pick(elig, base);
      if (pick[2]) begin
        state_d = OWN;
        gnt_d   = 4'b0001 << pick[1:0];
        sel_d   = pick[1:0];
        ptr_d   = pick[1:0];
        cnt_d   = CNT_W'(1);
      end else begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd3;
      cnt_q    <= '0;
      GNT      <= 4'b0000;
      SEL      <= 2'd0;
      OUT      <= '0;
      VALID    <= 1'b0;
      HOLD_EXP <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      GNT      <= gnt_d;
      SEL      <= sel_d;
      OUT      <= out_d;
      VALID    <= valid_d;
      HOLD_EXP <= hold_d;
    end
  end

endmodule

// File: tb/tb_bus_arb4.sv
// Bench for bus_arb4: directed vector table, hand-written corner sequences and a random run
// against a simple ownership model, on a MAX_HOLD=8 and a MAX_HOLD=4 instance.
module tb_bus_arb4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  REQ, LAST;
  logic [31:0] X0, X1, X2, X3;
  logic [3:0]  g8, g4;
  logic [1:0]  s8, s4;
  logic [31:0] o8, o4;
  logic        v8, v4, h8, h4;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  bus_arb4 #(.DATA_W(32), .MAX_HOLD(8)) dut8 (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .LAST(LAST),
    .X0(X0), .X1(X1), .X2(X2), .X3(X3),
    .GNT(g8), .SEL(s8), .OUT(o8), .VALID(v8), .HOLD_EXP(h8));

  bus_arb4 #(.DATA_W(32), .MAX_HOLD(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .LAST(LAST),
    .X0(X0), .X1(X1), .X2(X2), .X3(X3),
    .GNT(g4), .SEL(s4), .OUT(o4), .VALID(v4), .HOLD_EXP(h4));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Directed vectors: inputs before an edge, registered outputs after it.
  typedef struct {
    logic [3:0]  req;
    logic [3:0]  last;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [31:0] out;
    logic        valid;
    logic        hexp;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [3:0] req, input logic [3:0] last, input logic [3:0] gnt,
                     input logic [1:0] sel, input logic [31:0] out, input logic valid,
                     input logic hexp);
    vec_t v;
    v.req = req; v.last = last; v.gnt = gnt; v.sel = sel;
    v.out = out; v.valid = valid; v.hexp = hexp;
    vq.push_back(v);
  endtask

  // Ownership model: owner -1 means idle.
  typedef struct {
    int          owner;
    int          ptr;
    int          cnt;
    int          sel;
    logic [31:0] out;
    logic        valid;
    logic        hexp;
  } mdl_t;

  function automatic mdl_t mreset();
    mdl_t m;
    m.owner = -1; m.ptr = 3; m.cnt = 0; m.sel = 0;
    m.out = 32'h0; m.valid = 1'b0; m.hexp = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input logic [3:0] req, input logic [3:0] last,
                                 input logic [3:0][31:0] xs, input int maxh);
    mdl_t n;
    bit   rearb;
    int   base, w, j;
    n = m;
    n.hexp = 1'b0;
    rearb = 0;
    base = m.ptr;
    if (m.owner < 0) begin
      n.valid = 1'b0;
      rearb = (req != 4'b0);
    end else begin
      base = m.owner;
      if (!req[m.owner]) begin
        n.valid = 1'b0;
        rearb = 1;
      end else begin
        n.out = xs[m.owner];
        n.valid = 1'b1;
        if (m.cnt == maxh) begin
          n.hexp = 1'b1;
          rearb = 1;
        end else if (last[m.owner]) begin
          rearb = 1;
        end else begin
          n.cnt = m.cnt + 1;
        end
      end
    end
    if (rearb) begin
      w = -1;
      for (int k = 1; k <= 4; k++) begin
        j = (base + k) % 4;
        if (w < 0 && req[j]) w = j;
      end
      if (w >= 0) begin
        n.owner = w; n.sel = w; n.ptr = w; n.cnt = 1;
      end else begin
        n.owner = -1;
      end
    end
    return n;
  endfunction

  task automatic cmp_model(input string tag, input mdl_t m, input logic [3:0] g, input logic [1:0] s,
                           input logic [31:0] o, input logic v, input logic h);
    logic [3:0] eg;
    eg = (m.owner < 0) ? 4'b0000 : 4'(1 << m.owner);
    chk({tag, " gnt"}, 32'(g), 32'(eg));
    chk({tag, " sel"}, 32'(s), 32'(m.sel));
    chk({tag, " out"}, o, m.out);
    chk({tag, " valid"}, 32'(v), 32'(m.valid));
    chk({tag, " hold_exp"}, 32'(h), 32'(m.hexp));
  endtask

  initial begin
    mdl_t m8, m4;
    logic [3:0] rq, ls;
    logic [3:0][31:0] xs;

    RST_N = 1'b0; REQ = 4'b0; LAST = 4'b0;
    X0 = 32'hDEADBEEF; X1 = 32'h11111111; X2 = 32'h22222222; X3 = 32'h33333333;
    #12;
    chk("reset gnt", 32'(g8), 32'h0);
    chk("reset sel", 32'(s8), 32'h0);
    chk("reset out", o8, 32'h0);
    chk("reset valid", 32'(v8), 32'h0);
    chk("reset hold_exp", 32'(h8), 32'h0);
    RST_N = 1'b1;

    // Round-robin with every LAST held: one beat each, 0,1,2,3,0.
    add(4'hF, 4'hF, 4'b0001, 2'd0, 32'h0,        1'b0, 1'b0);
    add(4'hF, 4'hF, 4'b0010, 2'd1, 32'hDEADBEEF, 1'b1, 1'b0);
    add(4'hF, 4'hF, 4'b0100, 2'd2, 32'h11111111, 1'b1, 1'b0);
    add(4'hF, 4'hF, 4'b1000, 2'd3, 32'h22222222, 1'b1, 1'b0);
    add(4'hF, 4'hF, 4'b0001, 2'd0, 32'h33333333, 1'b1, 1'b0);
    add(4'h0, 4'h0, 4'b0000, 2'd0, 32'h33333333, 1'b0, 1'b0);
    // Single requester, LAST in the third grant cycle, then request drops.
    add(4'h1, 4'h0, 4'b0001, 2'd0, 32'h33333333, 1'b0, 1'b0);
    add(4'h1, 4'h0, 4'b0001, 2'd0, 32'hDEADBEEF, 1'b1, 1'b0);
    add(4'h1, 4'h0, 4'b0001, 2'd0, 32'hDEADBEEF, 1'b1, 1'b0);
    add(4'h1, 4'h1, 4'b0001, 2'd0, 32'hDEADBEEF, 1'b1, 1'b0);
    add(4'h0, 4'h0, 4'b0000, 2'd0, 32'hDEADBEEF, 1'b0, 1'b0);
    // Hold limit of 8 alternating between requesters 1 and 2.
    add(4'h6, 4'h0, 4'b0010, 2'd1, 32'hDEADBEEF, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) add(4'h6, 4'h0, 4'b0010, 2'd1, 32'h11111111, 1'b1, 1'b0);
    add(4'h6, 4'h0, 4'b0100, 2'd2, 32'h11111111, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) add(4'h6, 4'h0, 4'b0100, 2'd2, 32'h22222222, 1'b1, 1'b0);
    add(4'h6, 4'h0, 4'b0010, 2'd1, 32'h22222222, 1'b1, 1'b1);
    // Owner drops its request: no capture, immediate hand-over.
    add(4'h5, 4'h0, 4'b0100, 2'd2, 32'h22222222, 1'b0, 1'b0);
    add(4'h5, 4'h0, 4'b0100, 2'd2, 32'h22222222, 1'b1, 1'b0);
    add(4'h1, 4'h0, 4'b0001, 2'd0, 32'h22222222, 1'b0, 1'b0);
    add(4'h0, 4'h0, 4'b0000, 2'd0, 32'h22222222, 1'b0, 1'b0);

    foreach (vq[i]) begin
      REQ = vq[i].req; LAST = vq[i].last;
      @(posedge CLK); #1;
      chk($sformatf("vec%0d gnt", i), 32'(g8), 32'(vq[i].gnt));
      chk($sformatf("vec%0d sel", i), 32'(s8), 32'(vq[i].sel));
      chk($sformatf("vec%0d out", i), o8, vq[i].out);
      chk($sformatf("vec%0d valid", i), 32'(v8), 32'(vq[i].valid));
      chk($sformatf("vec%0d hold_exp", i), 32'(h8), 32'(vq[i].hexp));
    end

    // Sole requester 3 with hold limit 4: continuous grant, periodic HOLD_EXP.
    REQ = 4'b0; LAST = 4'b0;
    RST_N = 1'b0; #2; RST_N = 1'b1;
    REQ = 4'b1000;
    for (int k = 1; k <= 13; k++) begin
      @(posedge CLK); #1;
      chk($sformatf("sole%0d gnt4", k), 32'(g4), 32'h8);
      chk($sformatf("sole%0d valid4", k), 32'(v4), 32'(k >= 2));
      chk($sformatf("sole%0d hexp4", k), 32'(h4), 32'(k >= 5 && (k - 1) % 4 == 0));
      chk($sformatf("sole%0d gnt8", k), 32'(g8), 32'h8);
    end

    // Asynchronous reset between edges while requester 3 owns the bus.
    #2; RST_N = 1'b0; #1;
    chk("areset gnt8", 32'(g8), 32'h0);
    chk("areset out8", o8, 32'h0);
    chk("areset valid8", 32'(v8), 32'h0);
    chk("areset gnt4", 32'(g4), 32'h0);
    chk("areset hexp4", 32'(h4), 32'h0);
    REQ = 4'b1001;
    #2; RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("post-reset gnt8", 32'(g8), 32'h1);
    chk("post-reset sel8", 32'(s8), 32'h0);
    chk("post-reset gnt4", 32'(g4), 32'h1);

    // Random traffic against the model on both instances.
    RST_N = 1'b0; REQ = 4'b0; LAST = 4'b0; #1; RST_N = 1'b1;
    m8 = mreset(); m4 = mreset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        rq[b] = ($urandom_range(0, 9) < 7);
        ls[b] = ($urandom_range(0, 9) < 2);
      end
      REQ = rq; LAST = ls;
      X0 = $urandom; X1 = $urandom; X2 = $urandom; X3 = $urandom;
      xs = {X3, X2, X1, X0};
      @(posedge CLK); #1;
      m8 = mstep(m8, rq, ls, xs, 8);
      m4 = mstep(m4, rq, ls, xs, 4);
      cmp_model($sformatf("rnd%0d d8", c), m8, g8, s8, o8, v8, h8);
      cmp_model($sformatf("rnd%0d d4", c), m4, g4, s4, o4, v4, h4);
      if ($urandom_range(0, 499) == 0) begin
        RST_N = 1'b0; #1; RST_N = 1'b1;
        m8 = mreset(); m4 = mreset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
